// File: rtl/buf_receiver.sv
// Clocked consumer for the BUF output channel: 4-phase REQ/ACK capture into a FIFO,
// valid/ready output stream, saturating word count. Optional macro: BUF_RECEIVER_SEQ_CHECK_EN.
module buf_receiver #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned SEQ_LIMIT = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             BtoR_REQ,
    input  logic [WIDTH-1:0] DO,
    output logic             RtoB_ACK,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [7:0]       count,
    output logic             done,
    output logic             seq_err
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam logic [7:0]  Limit = 8'(SEQ_LIMIT);

    typedef enum logic [1:0] {StIdle, StAck, StGap} state_e;

    state_e           state_q, state_d;
    logic             req_m_q, req_s_q;
    logic             ack_q;
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [7:0]       count_q;
    logic             full, empty, push, pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty && out_ready;

    // Full is judged on current pointers, so a same-cycle pop never unblocks a push.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_s_q && !full) begin
                    push    = 1'b1;
                    state_d = StAck;
                end
            end
            StAck:   if (!req_s_q) state_d = StGap;
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_m_q  <= 1'b0;
            req_s_q  <= 1'b0;
            state_q  <= StIdle;
            ack_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            req_m_q <= BtoR_REQ;
            req_s_q <= req_m_q;
            state_q <= state_d;
            ack_q   <= (state_d == StAck);
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && (count_q != Limit)) count_q <= count_q + 8'd1;
        end
    end

    // Storage is only written on push, so DO is never sampled while req_s is low.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= DO;
    end

    assign RtoB_ACK  = ack_q;
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign count     = count_q;
    assign done      = (count_q == Limit);

`ifdef BUF_RECEIVER_SEQ_CHECK_EN
    logic [WIDTH-1:0] expected_q;
    logic             seq_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            expected_q <= '0;
            seq_err_q  <= 1'b0;
        end else if (push) begin
            if (DO != expected_q) seq_err_q <= 1'b1;
            expected_q <= DO + WIDTH'(1);
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && push && (DO != expected_q) && !seq_err_q)
            $display("buf_receiver: sequence error");
    end
`endif

    assign seq_err = seq_err_q;
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_buf_receiver.sv
// Scoreboard bench for buf_receiver: directed handshakes push expected words into a queue,
// a negedge monitor pops and compares every word the DUT delivers.
module tb_buf_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] do_w;
    logic        ack;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  count;
    logic        done;
    logic        seq_err;

    int          checks = 0;
    int          fails  = 0;
    int          rx     = 0;
    logic [31:0] exp_q[$];

`ifdef BUF_RECEIVER_SEQ_CHECK_EN
    localparam logic ExpSeqErr = 1'b1;
`else
    localparam logic ExpSeqErr = 1'b0;
`endif

    buf_receiver #(.WIDTH(32), .DEPTH(4), .SEQ_LIMIT(100)) dut (
        .clk      (clk),
        .rst      (rst),
        .BtoR_REQ (req),
        .DO       (do_w),
        .RtoB_ACK (ack),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count),
        .done     (done),
        .seq_err  (seq_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic v, input string name);
        for (int i = 0; i < 100; i++) begin
            tick();
            if (ack == v) begin
                checks++;
                return;
            end
        end
        checks++;
        fails++;
        $display("FAIL %s: RtoB_ACK got %0d, expected %0d within 100 cycles", name, ack, v);
    endtask

    task automatic send(input logic [31:0] w);
        do_w = w;
        req  = 1'b1;
        exp_q.push_back(w);
        wait_ack(1'b1, "ack_rise");
        req  = 1'b0;
        do_w = $urandom;
        wait_ack(1'b0, "ack_fall");
        tick();
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) begin
                checks++;
                return;
            end
            tick();
        end
        checks++;
        fails++;
        $display("FAIL drain: %0d words outstanding, expected 0", exp_q.size());
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        exp_q.delete();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_word", out_data, 32'hFFFF_FFFF);
            end else begin
                check("out_data", out_data, exp_q.pop_front());
                rx++;
            end
        end
    end

    initial begin
        int n;
        req       = 1'b0;
        do_w      = '0;
        out_ready = 1'b0;
        rst       = 1'b0;

        // Reset state and single handshake latency
        do_reset();
        check("rst_ack", {31'd0, ack}, 0);
        check("rst_valid", {31'd0, out_valid}, 0);
        check("rst_data", out_data, 0);
        check("rst_count", {24'd0, count}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_seq_err", {31'd0, seq_err}, 0);

        do_w = 32'd5;
        req  = 1'b1;
        exp_q.push_back(32'd5);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (ack) break;
        end
        check("ack_latency", n, 3);
        check("t1_valid", {31'd0, out_valid}, 1);
        check("t1_data", out_data, 5);
        check("t1_count", {24'd0, count}, 1);
        req = 1'b0;
        wait_ack(1'b0, "t1_ack_fall");
        check("ack_fall_lat_ack", {31'd0, ack}, 0);
        out_ready = 1'b1;
        drain();

        // Full sequence 0..99 then one extra word to prove saturation
        do_reset();
        rx = 0;
        for (int i = 0; i < 100; i++) send(32'(i));
        drain();
        check("seq_count", {24'd0, count}, 100);
        check("seq_done", {31'd0, done}, 1);
        check("seq_err_clean", {31'd0, seq_err}, 0);
        send(32'd100);
        drain();
        check("sat_count", {24'd0, count}, 100);
        check("sat_done", {31'd0, done}, 1);
        check("rx_total", rx, 101);

        // Back-pressure: four buffered, fifth held until a pop
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(32'(i));
        do_w = 32'd4;
        req  = 1'b1;
        exp_q.push_back(32'd4);
        repeat (20) tick();
        check("bp_ack_held", {31'd0, ack}, 0);
        check("bp_count", {24'd0, count}, 4);
        check("bp_head", out_data, 0);
        out_ready = 1'b1;
        wait_ack(1'b1, "bp_ack_rise");
        req = 1'b0;
        wait_ack(1'b0, "bp_ack_fall");
        drain();
        check("bp_count5", {24'd0, count}, 5);

        // Sequence check with a skipped word
        do_reset();
        send(32'd0);
        send(32'd1);
        check("seq_ok_01", {31'd0, seq_err}, 0);
        send(32'd3);
        check("seq_err_set", {31'd0, seq_err}, {31'd0, ExpSeqErr});
        send(32'd4);
        check("seq_err_sticky", {31'd0, seq_err}, {31'd0, ExpSeqErr});
        drain();

        // Reset while in ACK with two words buffered, REQ kept high
        do_reset();
        out_ready = 1'b0;
        send(32'd10);
        do_w = 32'd11;
        req  = 1'b1;
        wait_ack(1'b1, "mid_ack_rise");
        rst = 1'b1;
        tick();
        check("mid_rst_ack", {31'd0, ack}, 0);
        check("mid_rst_valid", {31'd0, out_valid}, 0);
        check("mid_rst_count", {24'd0, count}, 0);
        exp_q.delete();
        rst = 1'b0;
        exp_q.push_back(32'd11);
        wait_ack(1'b1, "recap_ack_rise");
        check("recap_count", {24'd0, count}, 1);
        check("recap_data", out_data, 11);
        req = 1'b0;
        wait_ack(1'b0, "recap_ack_fall");
        out_ready = 1'b1;
        drain();

        // Same-cycle push and pop at occupancy 1, across pointer wrap
        do_reset();
        out_ready = 1'b0;
        send(32'd20);
        for (int k = 21; k < 27; k++) begin
            do_w = 32'(k);
            req  = 1'b1;
            exp_q.push_back(32'(k));
            tick();
            tick();
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check("pp_ack", {31'd0, ack}, 1);
            check("pp_valid", {31'd0, out_valid}, 1);
            check("pp_head", out_data, 32'(k));
            check("pp_count", {24'd0, count}, 32'(k - 19));
            req = 1'b0;
            wait_ack(1'b0, "pp_ack_fall");
            tick();
            tick();
        end
        check("pp_occupancy", exp_q.size(), 1);
        out_ready = 1'b1;
        drain();
        tick();
        check("final_empty", {31'd0, out_valid}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
